aes256_ctr_arbiter: RTL

//  Shares one aes256_ctr keystream core between NUM_REQ requesters. It arbitrates round-robin,

---
 rtl/aes256_ctr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/aes256_ctr_arbiter.sv
// Round-robin arbiter that shares one AES-256 CTR keystream core among NUM_REQ requesters.
// Define AES_ARB_KEY_CACHE_EN to skip SET_KEY when the granted key matches the last loaded key.
module aes256_ctr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [NUM_REQ*256-1:0] KEY_IN,
  input  logic [NUM_REQ*128-1:0] CTR_IN,
  output logic [NUM_REQ-1:0]     ACK,
  output logic [127:0]           DOUT,
  output logic [IDW-1:0]         GNT_ID,
  output logic                   ARB_BUSY,
  output logic                   CORE_SET_KEY,
  output logic                   CORE_SET_COUNT,
  output logic                   CORE_START_ENC,
  output logic [255:0]           CORE_KEY_IN,
  output logic [127:0]           CORE_DATA_IN,
  input  logic                   CORE_BUSY,
  input  logic [127:0]           CORE_DATA_OUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_WAIT_KEY, S_LOAD_CTR,
    S_WAIT_CTR, S_ENC, S_WAIT_ENC, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_sel;
  logic [NUM_REQ-1:0] req_rot;
  logic             found;
  int               off;
  int               sum;
  logic [255:0]     key_sel;
  logic [127:0]     ctr_sel;
  logic             start;
  logic             key_hit;

  // Rotate requests so the RR pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_rot = NUM_REQ'({REQ, REQ} >> rr_ptr);
    off     = 0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_rot[k] && !found) begin
        off   = k;
        found = 1'b1;
      end
    end
    sum = int'(rr_ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    gnt_sel = IDW'(sum);
  end

  always_comb begin
    key_sel = '0;
    ctr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_sel == IDW'(i)) begin
        key_sel = KEY_IN[256*i +: 256];
        ctr_sel = CTR_IN[128*i +: 128];
      end
    end
  end

  assign start = (|REQ) && !CORE_BUSY;

`ifdef AES_ARB_KEY_CACHE_EN
  logic [255:0] last_key;
  logic         key_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      key_valid <= 1'b0;
    end else if (state == S_LOAD_KEY) begin
      key_valid <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == S_LOAD_KEY) last_key <= CORE_KEY_IN;
  end

  assign key_hit = key_valid && (key_sel == last_key);
`else
  assign key_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      GNT_ID       <= '0;
      CORE_KEY_IN  <= '0;
      CORE_DATA_IN <= '0;
      DOUT         <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        GNT_ID       <= gnt_sel;
        CORE_KEY_IN  <= key_sel;
        CORE_DATA_IN <= ctr_sel;
      end
      if (state == S_WAIT_ENC && !CORE_BUSY) DOUT <= CORE_DATA_OUT;
      if (state == S_DONE) begin
        rr_ptr <= (GNT_ID == IDW'(NUM_REQ - 1)) ? '0 : GNT_ID + 1'b1;
      end
    end
  end

  // Command pulses are decoded from the registered state, so each lasts exactly one cycle.
  always_comb begin
    state_nxt      = state;
    CORE_SET_KEY   = 1'b0;
    CORE_SET_COUNT = 1'b0;
    CORE_START_ENC = 1'b0;
    ARB_BUSY       = (state != S_IDLE);
    case (state)
      S_IDLE:     if (start) state_nxt = key_hit ? S_LOAD_CTR : S_LOAD_KEY;
      S_LOAD_KEY: begin
        CORE_SET_KEY = 1'b1;
        state_nxt    = S_WAIT_KEY;
      end
      S_WAIT_KEY: if (!CORE_BUSY) state_nxt = S_LOAD_CTR;
      S_LOAD_CTR: begin
        CORE_SET_COUNT = 1'b1;
        state_nxt      = S_WAIT_CTR;
      end
      S_WAIT_CTR: if (!CORE_BUSY) state_nxt = S_ENC;
      S_ENC: begin
        CORE_START_ENC = 1'b1;
        state_nxt      = S_WAIT_ENC;
      end
      S_WAIT_ENC: if (!CORE_BUSY) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ACK = '0;
    if (state == S_DONE) ACK[GNT_ID] = 1'b1;
  end

endmodule
